// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : Serial-to-parallel UART receiver (8N1 by default, LSB first,
//             line idle high, one stop bit). Each good byte is delivered with
//             a one-cycle o_valid strobe. A bad stop bit gives a one-cycle
//             o_frame_error strobe instead.
//
//  Parameters
//    CLKS_PER_BIT : clk cycles per bit period (>= 4)
//    DATA_BITS    : data bits per frame (5..8)
//
//  Ports
//    clk            in   system clock
//    i_reset        in   asynchronous reset, active low
//    i_rx           in   asynchronous serial line, idle high
//    o_data         out  last good byte, bit 0 = first data bit received
//    o_valid        out  one-cycle pulse when o_data is updated
//    o_frame_error  out  one-cycle pulse on a bad stop bit
//    o_busy         out  high whenever the receiver is not idle
//    o_parity_error out  (UART_RX_PARITY_EN only) one-cycle pulse with
//                        o_valid when the even-parity bit mismatches
//
//  Build option
//    UART_RX_PARITY_EN : adds one even-parity bit between data and stop
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_error,
    output logic                 o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 o_parity_error
`endif
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_END  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);

    // S_PARITY is only reachable when the parity option is compiled in.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_rx_s;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   w_half_tick;
    logic                   w_bit_tick;
    logic                   w_state_chg;
    logic                   w_shift_en;
    logic                   w_load;
    logic                   w_ferr;
`ifdef UART_RX_PARITY_EN
    logic                   r_par;
`endif

    assign w_rx_s      = r_sync2;
    assign w_half_tick = (r_cnt == c_HALF_END);
    assign w_bit_tick  = (r_cnt == c_BIT_END);
    assign w_state_chg = (w_next != r_state);
    assign o_busy      = (r_state != S_IDLE);

    // Two-flop synchronizer; presets high so reset looks like an idle line.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_load     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                // Mid start bit: a line back high means it was a glitch.
                if (w_half_tick) begin
                    w_next = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_next = S_PARITY;
`else
                        w_next = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop lets a back-to-back start bit be seen.
                if (w_bit_tick) begin
                    if (w_rx_s) begin
                        w_load = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait for the line to return high so a held-low line
                // cannot start a fresh frame.
                if (w_rx_s) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Baud counter restarts on every state change so each sample point is
    // measured from the edge that caused the transition.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (w_state_chg || w_bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_bit_cnt <= '0;
        end else if (r_state != S_DATA) begin
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift <= '0;
        end else begin
            for (int i = 0; i < DATA_BITS; i++) begin
                if (w_shift_en && (r_bit_cnt == c_BIT_W'(i))) begin
                    r_shift[i] <= w_rx_s;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_par <= 1'b0;
        end else if ((r_state == S_PARITY) && w_bit_tick) begin
            r_par <= w_rx_s;
        end
    end

    // Even parity: data bits plus parity bit must hold an even count of ones.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_parity_error <= 1'b0;
        end else begin
            o_parity_error <= w_load & (r_par ^ (^r_shift));
        end
    end
`endif

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_valid       <= w_load;
            o_frame_error <= w_ferr;
            if (w_load) begin
                o_data <= r_shift;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver (CLKS_PER_BIT=16,
//             DATA_BITS=8). Frames are driven bit by bit; a reference
//             model predicts the strobe cycle and content of every frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB  = 1;
    localparam int LAT_LIT = 171;
`else
    localparam int PB  = 0;
    localparam int LAT_LIT = 155;
`endif
    // Strobe cycle after the start-bit falling edge (sync + half bit + bits).
    localparam int LAT = 3 + CPB / 2 + (DB + 1 + PB) * CPB;

    logic          clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_rx = 1'b1;
    logic [DB-1:0] o_data;
    logic          o_valid;
    logic          o_frame_error;
    logic          o_busy;
`ifdef UART_RX_PARITY_EN
    logic          o_parity_error;
`endif

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_rx          (i_rx),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_frame_error (o_frame_error),
        .o_busy        (o_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_error(o_parity_error)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         err;
        bit         perr;
        logic [7:0] data;
    } ev_t;

    ev_t        q[$];
    logic [7:0] m_data = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         last_cyc = 0;
    int         last_start = 0;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, against the model's expected events.
    always @(negedge clk) begin
        ev_t e;
        if (!i_reset) begin
            m_data = 8'h00;
            chk("reset_valid", 32'(o_valid), 32'd0);
            chk("reset_ferr", 32'(o_frame_error), 32'd0);
            chk("reset_busy", 32'(o_busy), 32'd0);
            chk("reset_data", 32'(o_data), 32'd0);
`ifdef UART_RX_PARITY_EN
            chk("reset_perr", 32'(o_parity_error), 32'd0);
`endif
        end else begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("strobe_valid", 32'(o_valid), 32'(!e.err));
                chk("strobe_ferr", 32'(o_frame_error), 32'(e.err));
`ifdef UART_RX_PARITY_EN
                chk("strobe_perr", 32'(o_parity_error), 32'(e.perr && !e.err));
`endif
                if (!e.err) m_data = e.data;
            end else begin
                chk("quiet_valid", 32'(o_valid), 32'd0);
                chk("quiet_ferr", 32'(o_frame_error), 32'd0);
`ifdef UART_RX_PARITY_EN
                chk("quiet_perr", 32'(o_parity_error), 32'd0);
`endif
            end
            chk("data_hold", 32'(o_data), 32'(m_data));
        end
        if (o_valid) begin
            n_valid++;
            last_cyc  = cyc;
            last_data = o_data;
        end
        if (o_frame_error) n_ferr++;
`ifdef UART_RX_PARITY_EN
        if (o_parity_error) n_perr++;
`endif
    end

    // All drive tasks run just after a rising edge.
    task automatic hold(input logic v, input int n);
        i_rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int extra_low, input bit par_flip);
        ev_t        e;
        logic [7:0] sh;
        e.cyc  = cyc + LAT;
        e.err  = !stop_ok;
        e.perr = par_flip;
        e.data = d;
        q.push_back(e);
        last_start = cyc;
        hold(1'b0, CPB);
        sh = d;
        for (int i = 0; i < DB; i++) begin
            hold(sh[0], CPB);
            sh = sh >> 1;
        end
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_flip, CPB);
`endif
        hold(stop_ok, CPB);
        if (!stop_ok) hold(1'b0, extra_low);
        i_rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int v0;
        int f0;
        int p0;
        int kind;
        int gap;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b1;
        hold(1'b1, 4);
        chk("post_reset_busy", 32'(o_busy), 32'd0);

        // Single frame 0xA5 with exact strobe latency.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        hold(1'b1, 4);
        chk("a5_count", 32'(n_valid - v0), 32'd1);
        chk("a5_data", 32'(last_data), 32'hA5);
        chk("a5_latency", 32'(last_cyc - last_start), 32'(LAT_LIT));
        chk("a5_busy", 32'(o_busy), 32'd0);
        chk("a5_no_ferr", 32'(n_ferr - f0), 32'd0);

        // Back-to-back frames, no idle gap.
        v0 = n_valid;
        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        hold(1'b1, 4);
        chk("b2b_count", 32'(n_valid - v0), 32'd3);
        chk("b2b_last", 32'(last_data), 32'h3C);

        // Start-bit glitch.
        v0 = n_valid; f0 = n_ferr;
        hold(1'b0, 4);
        hold(1'b1, 10);
        chk("glitch_busy", 32'(o_busy), 32'd0);
        hold(1'b1, CPB);
        chk("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        chk("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);

        // Frame error and break recovery.
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        f0 = n_ferr;
        send_frame(8'hC3, 1'b0, 40, 1'b0);
        chk("ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("ferr_data_kept", 32'(o_data), 32'h5A);
        hold(1'b1, 4);
        v0 = n_valid;
        send_frame(8'h81, 1'b1, 0, 1'b0);
        hold(1'b1, 4);
        chk("after_break_count", 32'(n_valid - v0), 32'd1);
        chk("after_break_data", 32'(last_data), 32'h81);

        // Reset during data bit 4 of 0xF0.
        v0 = n_valid;
        hold(1'b0, CPB);
        hold(1'b0, 4 * CPB);
        hold(1'b1, 5);
        i_reset = 1'b0;
        q.delete();
        hold(1'b1, 3);
        i_reset = 1'b1;
        hold(1'b1, CPB);
        chk("reset_partial_data", 32'(o_data), 32'h00);
        send_frame(8'h12, 1'b1, 0, 1'b0);
        hold(1'b1, 4);
        chk("reset_partial_count", 32'(n_valid - v0), 32'd1);
        chk("after_reset_data", 32'(last_data), 32'h12);

`ifdef UART_RX_PARITY_EN
        p0 = n_perr;
        send_frame(8'h07, 1'b1, 0, 1'b0);
        hold(1'b1, 4);
        chk("par_good", 32'(n_perr - p0), 32'd0);
        send_frame(8'h07, 1'b1, 0, 1'b1);
        hold(1'b1, 4);
        chk("par_bad", 32'(n_perr - p0), 32'd1);
        chk("par_bad_data", 32'(last_data), 32'h07);
`else
        p0 = n_perr;
`endif

        // Randomized traffic: good frames, bad stops, glitches, varied gaps.
        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                hold(1'b0, int'($urandom_range(1, 6)));
                hold(1'b1, CPB);
            end else if (kind == 1) begin
                send_frame(b, 1'b0, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
                hold(1'b1, 2 + int'($urandom_range(0, CPB)));
            end else begin
                send_frame(b, 1'b1, 0, 1'($urandom_range(0, 1)));
                gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
                hold(1'b1, gap);
            end
        end

        hold(1'b1, LAT + 10);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_idle", 32'(o_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
